// File: rtl/router_link_input_port_if.sv
// rtl/router_link_input_port_if.sv - link-side and crossbar-side signals of the router input port
interface router_link_input_port_if #(
    parameter int DATA_W = 32
);
    logic              in_req;
    logic [DATA_W-1:0] in_data;
    logic              in_ack;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_port;
    logic [15:0]       flit_cnt;

    modport master (
        output in_req, in_data, out_ready,
        input  in_ack, out_valid, out_data, out_port, flit_cnt
    );

    modport slave (
        input  in_req, in_data, out_ready,
        output in_ack, out_valid, out_data, out_port, flit_cnt
    );
endinterface

// File: rtl/router_link_input_port.sv
// rtl/router_link_input_port.sv - two-phase link terminator with synchroniser, DOR route and flit FIFO
module router_link_input_port #(
    parameter int DATA_W      = 32,
    parameter int COORD_W     = 1,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit DOR_YX      = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    router_link_input_port_if.slave lnk
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ENT_W  = DATA_W + 3;
    localparam int HX_LSB = DATA_W - 2 - COORD_W;
    localparam int HY_LSB = DATA_W - 2 - 2 * COORD_W;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_XPOS  = 3'd1;
    localparam logic [2:0] P_XNEG  = 3'd2;
    localparam logic [2:0] P_YPOS  = 3'd3;
    localparam logic [2:0] P_YNEG  = 3'd4;

    // FIFO entries carry the routed port in the top three bits above the flit
    typedef logic [ENT_W-1:0] entry_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_seen_q, req_seen_d;
    logic                   ack_q, ack_d;
    logic [15:0]            flit_cnt_q, flit_cnt_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    entry_t                 mem_q [DEPTH];
    entry_t                 mem_d [DEPTH];
    entry_t                 head_q, head_d;
    logic                   valid_q, valid_d;

    logic                   ev, full, push, pop;
    logic                   dir_x, dir_y;
    logic [COORD_W-1:0]     hops_x, hops_y;
    entry_t                 new_entry;

    always_comb begin
        dir_x     = lnk.in_data[DATA_W-1];
        dir_y     = lnk.in_data[DATA_W-2];
        hops_x    = lnk.in_data[HX_LSB +: COORD_W];
        hops_y    = lnk.in_data[HY_LSB +: COORD_W];
        new_entry = {P_LOCAL, lnk.in_data};
        if (DOR_YX) begin
            if (hops_y != '0) begin
                new_entry[ENT_W-1 -: 3]         = dir_y ? P_YPOS : P_YNEG;
                new_entry[HY_LSB +: COORD_W]    = hops_y - 1'b1;
            end else if (hops_x != '0) begin
                new_entry[ENT_W-1 -: 3]         = dir_x ? P_XPOS : P_XNEG;
                new_entry[HX_LSB +: COORD_W]    = hops_x - 1'b1;
            end
        end else begin
            if (hops_x != '0) begin
                new_entry[ENT_W-1 -: 3]         = dir_x ? P_XPOS : P_XNEG;
                new_entry[HX_LSB +: COORD_W]    = hops_x - 1'b1;
            end else if (hops_y != '0) begin
                new_entry[ENT_W-1 -: 3]         = dir_y ? P_YPOS : P_YNEG;
                new_entry[HY_LSB +: COORD_W]    = hops_y - 1'b1;
            end
        end
    end

    always_comb begin
        ev   = sync_q[SYNC_STAGES-1] ^ req_seen_q;
        // full is judged before any same-edge pop, so a waiting event never bypasses
        full = (count_q == CNT_W'(DEPTH));
        push = ev & ~full;
        pop  = valid_q & lnk.out_ready;

        sync_d     = {sync_q[SYNC_STAGES-2:0], lnk.in_req};
        req_seen_d = push ? sync_q[SYNC_STAGES-1] : req_seen_q;
        ack_d      = ack_q ^ push;
        flit_cnt_d = flit_cnt_q + {15'd0, push};
        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = new_entry;

        // head comes from storage when a pop leaves older entries, else straight from the link
        head_d = head_q;
        if (count_d == '0)
            head_d = '0;
        else if (pop && count_q >= CNT_W'(2))
            head_d = mem_q[rd_ptr_d];
        else if (pop || count_q == '0)
            head_d = new_entry;
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            req_seen_q <= 1'b0;
            ack_q      <= 1'b0;
            flit_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_q      <= '{default: '0};
            head_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            req_seen_q <= req_seen_d;
            ack_q      <= ack_d;
            flit_cnt_q <= flit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
        end
    end

    assign lnk.in_ack    = ack_q;
    assign lnk.out_valid = valid_q;
    assign lnk.out_data  = head_q[DATA_W-1:0];
    assign lnk.out_port  = head_q[ENT_W-1 -: 3];
    assign lnk.flit_cnt  = flit_cnt_q;
endmodule

// File: tb/tb_router_link_input_port.sv
// tb/tb_router_link_input_port.sv - XY and YX instances fed one random/directed flit stream against a queue model
module tb_router_link_input_port;
    localparam int DATA_W      = 32;
    localparam int COORD_W     = 1;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HX_LSB      = DATA_W - 2 - COORD_W;
    localparam int HY_LSB      = DATA_W - 2 - 2 * COORD_W;

    logic clk;
    logic rst_n;
    logic req;
    logic [DATA_W-1:0] in_data_r;
    logic out_ready;

    int checks = 0;
    int errors = 0;

    logic              exp_ack;
    logic [15:0]       exp_cnt;
    bit                pending;
    int                rem;
    logic [DATA_W-1:0] pend_data;
    logic [DATA_W+2:0] q_xy[$];
    logic [DATA_W+2:0] q_yx[$];
    bit                rand_rdy;

    router_link_input_port_if #(.DATA_W(DATA_W)) ifx ();
    router_link_input_port_if #(.DATA_W(DATA_W)) ify ();

    assign ifx.in_req    = req;
    assign ifx.in_data   = in_data_r;
    assign ifx.out_ready = out_ready;
    assign ify.in_req    = req;
    assign ify.in_data   = in_data_r;
    assign ify.out_ready = out_ready;

    router_link_input_port #(.DATA_W(DATA_W), .COORD_W(COORD_W), .DEPTH(DEPTH),
                             .SYNC_STAGES(SYNC_STAGES), .DOR_YX(1'b0))
        dut_xy (.clk(clk), .rst_n(rst_n), .lnk(ifx.slave));

    router_link_input_port #(.DATA_W(DATA_W), .COORD_W(COORD_W), .DEPTH(DEPTH),
                             .SYNC_STAGES(SYNC_STAGES), .DOR_YX(1'b1))
        dut_yx (.clk(clk), .rst_n(rst_n), .lnk(ify.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dimension-ordered route: walk the two dimensions in preference order, take the first non-zero one
    function automatic logic [DATA_W+2:0] ref_route(input logic [DATA_W-1:0] f, input bit yx);
        int hop [2];
        bit dir [2];
        int port;
        bit moved;
        int d;
        hop[0] = int'(f[HX_LSB +: COORD_W]);
        hop[1] = int'(f[HY_LSB +: COORD_W]);
        dir[0] = f[DATA_W-1];
        dir[1] = f[DATA_W-2];
        port   = 0;
        moved  = 0;
        for (int k = 0; k < 2; k++) begin
            d = yx ? 1 - k : k;
            if (!moved && hop[d] != 0) begin
                port   = 1 + 2 * d + (dir[d] ? 0 : 1);
                hop[d] = (hop[d] - 1) % (1 << COORD_W);
                moved  = 1;
            end
        end
        f[HX_LSB +: COORD_W] = COORD_W'(hop[0]);
        f[HY_LSB +: COORD_W] = COORD_W'(hop[1]);
        return {3'(port), f};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ack_xy",   64'(ifx.in_ack),    64'(exp_ack));
        chk("ack_yx",   64'(ify.in_ack),    64'(exp_ack));
        chk("cnt_xy",   64'(ifx.flit_cnt),  64'(exp_cnt));
        chk("cnt_yx",   64'(ify.flit_cnt),  64'(exp_cnt));
        chk("valid_xy", 64'(ifx.out_valid), 64'(q_xy.size() != 0));
        chk("valid_yx", 64'(ify.out_valid), 64'(q_yx.size() != 0));
        if (q_xy.size() != 0) begin
            chk("data_xy", 64'(ifx.out_data), 64'(q_xy[0][DATA_W-1:0]));
            chk("port_xy", 64'(ifx.out_port), 64'(q_xy[0][DATA_W+2:DATA_W]));
        end
        if (q_yx.size() != 0) begin
            chk("data_yx", 64'(ify.out_data), 64'(q_yx[0][DATA_W-1:0]));
            chk("port_yx", 64'(ify.out_port), 64'(q_yx[0][DATA_W+2:DATA_W]));
        end
    endtask

    // Called at a falling edge; advances one rising edge and updates the model from pre-edge state
    task automatic tick();
        bit pop_now;
        bit do_push;
        pop_now = out_ready && (q_xy.size() != 0);
        do_push = 0;
        if (pending && rst_n) begin
            if (rem > 1) rem--;
            else if (q_xy.size() < DEPTH) do_push = 1;
        end
        @(posedge clk);
        if (pop_now && rst_n) begin
            void'(q_xy.pop_front());
            void'(q_yx.pop_front());
        end
        if (do_push) begin
            q_xy.push_back(ref_route(pend_data, 1'b0));
            q_yx.push_back(ref_route(pend_data, 1'b1));
            pending = 0;
            exp_ack = ~exp_ack;
            exp_cnt = exp_cnt + 16'd1;
        end
        @(negedge clk);
        check_all();
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic toggle_req(input logic [DATA_W-1:0] data);
        in_data_r = data;
        req       = ~req;
        pend_data = data;
        pending   = 1;
        rem       = SYNC_STAGES + 1;
    endtask

    task automatic wait_accept(output int n, input int bound);
        logic target;
        target = ~exp_ack;
        n = 0;
        while (ifx.in_ack !== target && n < bound) begin
            tick();
            n++;
        end
        chk("accept", 64'(ifx.in_ack), 64'(target));
    endtask

    task automatic model_reset();
        q_xy.delete();
        q_yx.delete();
        exp_ack = 1'b0;
        exp_cnt = 16'd0;
        pending = 0;
        rem     = 0;
    endtask

    int n;
    int pops;
    logic ack_hold;

    initial begin
        rst_n     = 1'b0;
        req       = 1'b0;
        in_data_r = '0;
        out_ready = 1'b0;
        rand_rdy  = 0;
        model_reset();

        #1;
        chk("rst_ack",   64'(ifx.in_ack),    64'(0));
        chk("rst_valid", 64'(ifx.out_valid), 64'(0));
        chk("rst_data",  64'(ifx.out_data),  64'(0));
        chk("rst_port",  64'(ifx.out_port),  64'(0));
        chk("rst_cnt",   64'(ifx.flit_cnt),  64'(0));
        chk("rst_valid_yx", 64'(ify.out_valid), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();

        // XY single hop east: three-edge latency, hop field consumed
        out_ready = 1'b1;
        toggle_req({1'b1, 1'b0, 1'b1, 1'b0, 28'hEEEEEEE});
        wait_accept(n, 20);
        chk("t1_latency", 64'(n), 64'(3));
        chk("t1_port", 64'(ifx.out_port), 64'(1));
        chk("t1_data", 64'(ifx.out_data), 64'({1'b1, 1'b0, 1'b0, 1'b0, 28'hEEEEEEE}));
        chk("t1_cnt",  64'(ifx.flit_cnt), 64'(1));
        tick();

        // already at destination: local port, flit untouched
        toggle_req({1'b1, 1'b1, 1'b0, 1'b0, 28'hCCCCCCC});
        wait_accept(n, 20);
        chk("t2_port_xy", 64'(ifx.out_port), 64'(0));
        chk("t2_port_yx", 64'(ify.out_port), 64'(0));
        chk("t2_data",    64'(ifx.out_data), 64'({1'b1, 1'b1, 1'b0, 1'b0, 28'hCCCCCCC}));
        tick();

        // both hops pending, south: YX takes Y first, XY takes X first
        toggle_req({1'b1, 1'b0, 1'b1, 1'b1, 28'h1234567});
        wait_accept(n, 20);
        chk("t3_port_yx", 64'(ify.out_port), 64'(4));
        chk("t3_data_yx", 64'(ify.out_data), 64'({1'b1, 1'b0, 1'b1, 1'b0, 28'h1234567}));
        chk("t3_port_xy", 64'(ifx.out_port), 64'(1));
        chk("t3_data_xy", 64'(ifx.out_data), 64'({1'b1, 1'b0, 1'b0, 1'b1, 28'h1234567}));
        tick();

        // random flits with random backpressure
        rand_rdy = 1;
        repeat (40) begin
            toggle_req($urandom);
            wait_accept(n, 200);
        end
        rand_rdy  = 0;
        out_ready = 1'b1;
        repeat (8) tick();

        // fill the FIFO; the fifth flit waits until a slot frees
        out_ready = 1'b0;
        repeat (4) begin
            toggle_req($urandom);
            wait_accept(n, 20);
        end
        ack_hold = exp_ack;
        toggle_req($urandom);
        repeat (8) tick();
        chk("t4_blocked", 64'(ifx.in_ack), 64'(ack_hold));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_accept(n, 10);
        chk("t4_late_ack", 64'(n), 64'(1));
        out_ready = 1'b1;
        repeat (6) tick();

        // push and pop on the same edge with two entries held
        out_ready = 1'b0;
        repeat (2) begin
            toggle_req($urandom);
            wait_accept(n, 20);
        end
        toggle_req($urandom);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t5_valid", 64'(ifx.out_valid), 64'(1));
        out_ready = 1'b1;
        pops = 0;
        while (ifx.out_valid && pops < 10) begin
            tick();
            pops++;
        end
        chk("t5_pops", 64'(pops), 64'(2));

        // counter wrap: preset near the top, then two more flits
        force dut_xy.flit_cnt_d = 16'hFFFE;
        force dut_yx.flit_cnt_d = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut_xy.flit_cnt_d;
        release dut_yx.flit_cnt_d;
        exp_cnt = 16'hFFFE;
        @(negedge clk);
        check_all();
        repeat (2) begin
            toggle_req($urandom);
            wait_accept(n, 20);
        end
        chk("t6_wrap_xy", 64'(ifx.flit_cnt), 64'(0));
        chk("t6_wrap_yx", 64'(ify.flit_cnt), 64'(0));
        repeat (3) tick();

        // asynchronous reset with three flits stored
        out_ready = 1'b0;
        repeat (3) begin
            toggle_req($urandom);
            wait_accept(n, 20);
        end
        #2;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk("t7_valid", 64'(ifx.out_valid), 64'(0));
        chk("t7_ack",   64'(ifx.in_ack),    64'(0));
        chk("t7_cnt",   64'(ifx.flit_cnt),  64'(0));
        chk("t7_data",  64'(ifx.out_data),  64'(0));
        chk("t7_port",  64'(ifx.out_port),  64'(0));
        chk("t7_valid_yx", 64'(ify.out_valid), 64'(0));
        model_reset();
        @(negedge clk);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        out_ready = 1'b1;
        toggle_req({1'b0, 1'b0, 1'b0, 1'b1, 28'hABCDEF0});
        wait_accept(n, 20);
        chk("t7_after_port_xy", 64'(ifx.out_port), 64'(4));
        chk("t7_after_cnt",     64'(ifx.flit_cnt), 64'(1));
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
